// File: rtl/fp_comp_pkg.sv
// Shared constants, leading-one helper and result word for the float compressor datapath.
// Default widths here match the fp_compress_pipe parameter defaults.
package fp_comp_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int EXP_W_DEF  = 3;
  localparam int MANT_W_DEF = 4;

  localparam int EXP_MAX  = (1 << EXP_W_DEF) - 1;
  localparam int MANT_MAX = (1 << MANT_W_DEF) - 1;

  typedef struct packed {
    logic                  s;
    logic [EXP_W_DEF-1:0]  e;
    logic [MANT_W_DEF-1:0] f;
    logic                  sat;
  } fp_word_t;

  // Index of the most significant set bit; 0 when no bit is set.
  function automatic int lead_one_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_comp_lod.sv
// Combinational leading-one detector for vectors up to 32 bits wide.
module fp_comp_lod
  import fp_comp_pkg::*;
#(
  parameter int W  = 11,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [PW-1:0] idx
);

  assign idx = PW'(lead_one_idx(32'(vec)));

endmodule

// File: rtl/fp_compress_pipe.sv
// Two-stage streaming linear-to-float compressor (sign, exponent, rounded mantissa, saturation).
// Define COMP_SAT_CNT_EN to add the sticky saturated-result counter on sat_count.
module fp_compress_pipe
  import fp_comp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
`ifdef COMP_SAT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_s,
  output logic [EXP_W-1:0]  out_e,
  output logic [MANT_W-1:0] out_f,
  output logic              out_sat
`ifdef COMP_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0]  sat_count
`endif
);

  localparam int MAG_W = DATA_W - 1;
  localparam int PW    = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic              adv;
  logic              s_in;
  logic [DATA_W-1:0] neg_in;
  logic [DATA_W-1:0] mag_full;
  logic [MAG_W-1:0]  mag_in;
  logic [PW-1:0]     p_in;

  logic              s1_v;
  logic              s1_s;
  logic [MAG_W-1:0]  s1_mag;
  logic [PW-1:0]     s1_p;

  logic [31:0]       mag32;
  logic [31:0]       sh;
  logic [31:0]       e_raw;
  logic [MANT_W-1:0] f_trunc;
  logic              r_bit;
  logic [MANT_W:0]   f_sum;
  logic [EXP_W-1:0]  e_nxt;
  logic [MANT_W-1:0] f_nxt;
  logic              sat_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: sign-magnitude; the most-negative code clamps to the largest magnitude.
  assign s_in     = in_data[DATA_W-1];
  assign neg_in   = -in_data;
  assign mag_full = s_in ? neg_in : in_data;
  assign mag_in   = mag_full[DATA_W-1] ? {MAG_W{1'b1}} : mag_full[MAG_W-1:0];

  fp_comp_lod #(.W(MAG_W), .PW(PW)) u_lod (
    .vec (mag_in),
    .idx (p_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_s   <= 1'b0;
      s1_mag <= '0;
      s1_p   <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_s   <= s_in;
        s1_mag <= mag_in;
        s1_p   <= p_in;
      end
    end
  end

  // Stage 2: mantissa window below the leading one, round half-up, then clamp.
  always_comb begin
    mag32   = 32'(s1_mag);
    sh      = '0;
    e_raw   = '0;
    f_trunc = '0;
    r_bit   = 1'b0;
    f_sum   = '0;
    e_nxt   = '0;
    f_nxt   = '0;
    sat_nxt = 1'b0;
    if (mag32 < (32'd1 << MANT_W)) begin
      f_trunc = MANT_W'(mag32);
    end else begin
      sh      = 32'(s1_p) - 32'(MANT_W) + 32'd1;
      e_raw   = sh;
      f_trunc = MANT_W'(mag32 >> sh);
      r_bit   = |(mag32 & (32'd1 << (sh - 32'd1)));
    end
    f_sum = {1'b0, f_trunc} + {{MANT_W{1'b0}}, r_bit};
    if (f_sum[MANT_W]) begin
      e_raw = e_raw + 32'd1;
      f_nxt = {1'b1, {(MANT_W-1){1'b0}}};
    end else begin
      f_nxt = f_sum[MANT_W-1:0];
    end
    if (e_raw > 32'(EMAX)) begin
      e_nxt   = '1;
      f_nxt   = '1;
      sat_nxt = 1'b1;
    end else begin
      e_nxt = EXP_W'(e_raw);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_s   <= s1_s;
        out_e   <= e_nxt;
        out_f   <= f_nxt;
        out_sat <= sat_nxt;
      end
    end
  end

`ifdef COMP_SAT_CNT_EN
  // Sticky at all ones so a long overload never reads back as a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_compress_pipe.sv
// Directed self-checking bench for fp_compress_pipe (default parameters).
// Define COMP_SAT_CNT_EN to also exercise the saturation counter.
module tb_fp_compress_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        out_sat;
`ifdef COMP_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int errors;
  int checks;

  fp_compress_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_sat   (out_sat)
`ifdef COMP_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        sat;
  } vec_t;

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_s !== 1'b0 || out_e !== 3'd0 || out_f !== 4'd0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b s=%b e=%0d f=%0h sat=%b want all 0", out_valid, out_s, out_e, out_f, out_sat);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
`ifdef COMP_SAT_CNT_EN
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_sat_count got %0h want 0", sat_count);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors;
    vec_t tbl[10];
    tbl[0] = '{12'h000, 1'b0, 3'd0, 4'h0, 1'b0};
    tbl[1] = '{12'hFFF, 1'b1, 3'd0, 4'h1, 1'b0};
    tbl[2] = '{12'h02E, 1'b0, 3'd2, 4'hC, 1'b0};
    tbl[3] = '{12'h07D, 1'b0, 3'd4, 4'h8, 1'b0};
    tbl[4] = '{12'h780, 1'b0, 3'd7, 4'hF, 1'b0};
    tbl[5] = '{12'h7FF, 1'b0, 3'd7, 4'hF, 1'b1};
    tbl[6] = '{12'h800, 1'b1, 3'd7, 4'hF, 1'b1};
    tbl[7] = '{12'hFD2, 1'b1, 3'd2, 4'hC, 1'b0};
    tbl[8] = '{12'h00F, 1'b0, 3'd0, 4'hF, 1'b0};
    tbl[9] = '{12'h010, 1'b0, 3'd1, 4'h8, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tbl[i].d;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early d=%h got out_valid=%b want 0", tbl[i].d, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_s !== tbl[i].s || out_e !== tbl[i].e || out_f !== tbl[i].f || out_sat !== tbl[i].sat) begin
        errors++;
        $display("FAIL vec d=%h got v=%b s=%b e=%0d f=%h sat=%b want v=1 s=%b e=%0d f=%h sat=%b",
                 tbl[i].d, out_valid, out_s, out_e, out_f, out_sat, tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].sat);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int         sent;
    int         rcvd;
    int         stall_cnt;
    logic       prev_stall;
    logic [3:0] prev_f;
    logic [2:0] prev_e;
    sent       = 0;
    rcvd       = 0;
    stall_cnt  = 0;
    prev_stall = 1'b0;
    prev_f     = '0;
    prev_e     = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 10);
      in_valid  = (sent < 8);
      in_data   = 12'(sent + 1);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== prev_f || out_e !== prev_e) begin
          errors++;
          $display("FAIL bp_hold got v=%b f=%h e=%0d want v=1 f=%h e=%0d", out_valid, out_f, out_e, prev_f, prev_e);
        end
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_f !== 4'(rcvd + 1) || out_e !== 3'd0 || out_s !== 1'b0 || out_sat !== 1'b0) begin
          errors++;
          $display("FAIL bp_order got s=%b e=%0d f=%h sat=%b want s=0 e=0 f=%h sat=0", out_s, out_e, out_f, out_sat, 4'(rcvd + 1));
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_f     = out_f;
      prev_e     = out_e;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcvd != 8) begin
      errors++;
      $display("FAIL bp_count got %0d results want 8", rcvd);
    end
    checks++;
    if (stall_cnt != 4) begin
      errors++;
      $display("FAIL bp_stall_cycles got %0d want 4", stall_cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h7FF;
    @(negedge clk);
    in_data  = 12'h010;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got v=%b sat=%b want v=0 sat=0", out_valid, out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stale got out_valid seen=%b want 0", seen);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h02E;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_e !== 3'd2 || out_f !== 4'hC || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_first got v=%b e=%0d f=%h sat=%b want v=1 e=2 f=c sat=0", out_valid, out_e, out_f, out_sat);
    end
    @(negedge clk);
  endtask

`ifdef COMP_SAT_CNT_EN
  task automatic test_sat_count;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h7FF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sat !== 1'b1 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL satcnt_held got v=%b sat=%b cnt=%0d want v=1 sat=1 cnt=0", out_valid, out_sat, sat_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h800;
    @(negedge clk);
    in_data  = 12'h7FF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sat_count !== 16'd3) begin
      errors++;
      $display("FAIL satcnt_three got %0d want 3", sat_count);
    end
    force dut.sat_count = 16'hFFFD;
    @(negedge clk);
    release dut.sat_count;
    in_valid = 1'b1;
    in_data  = 12'h800;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sat_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL satcnt_sticky got %h want ffff", sat_count);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
`ifdef COMP_SAT_CNT_EN
    test_sat_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
